// File: rtl/scv_pkg.sv
// Shared types for the scv ROMINIT download path: target select, sink FSM
// states and the smallest cartridge address mask.
package scv_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BOOT = 2'd1,
    CHR  = 2'd2,
    CART = 2'd3
  } rominit_tgt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    STRETCH = 2'd2,
    RUN     = 2'd3
  } rominit_state_t;

  localparam logic [16:0] CART_MASK_MIN = 17'h007FF;

  // Fixed priority boot > chr > cart when several selects are high.
  function automatic rominit_tgt_t pick_tgt(input logic sel_boot, input logic sel_chr,
                                            input logic sel_cart);
    if (sel_boot)      return BOOT;
    else if (sel_chr)  return CHR;
    else if (sel_cart) return CART;
    else               return NONE;
  endfunction

endpackage

// File: rtl/rominit_mask.sv
// Highest written cartridge address -> all-ones power-of-two address mask,
// never smaller than CART_MASK_MIN. Purely combinational.
module rominit_mask
  import scv_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic [AW-1:0] max_addr,
  output logic [AW-1:0] mask
);

  logic [AW-1:0] smear;

  // Every bit at or below the highest set bit of max_addr becomes 1, which is
  // 2^ceil(log2(max+1)) - 1 without any arithmetic.
  always_comb begin
    smear = '0;
    smear[AW-1] = max_addr[AW-1];
    for (int i = AW - 2; i >= 0; i--) begin
      smear[i] = smear[i+1] | max_addr[i];
    end
    mask = smear | AW'(CART_MASK_MIN);
  end

endmodule

// File: rtl/rominit_sink.sv
// ROMINIT download sink: steers bytes into boot/chr/cart ROM write ports and
// holds the console in reset until loaded. Optional checksums: ROMINIT_SINK_CKSUM_EN.
module rominit_sink
  import scv_pkg::*;
#(
  parameter int BOOT_AW    = 12,
  parameter int CHR_AW     = 10,
  parameter int CART_AW    = 17,
  parameter int RST_CYCLES = 1024
) (
  input  logic               CLK,
  input  logic               RESB,
  input  logic               ROMINIT_SEL_BOOT,
  input  logic               ROMINIT_SEL_CHR,
  input  logic               ROMINIT_SEL_CART,
  input  logic [16:0]        ROMINIT_ADDR,
  input  logic [7:0]         ROMINIT_DATA,
  input  logic               ROMINIT_VALID,
  output logic [7:0]         MEM_D,
  output logic               BOOT_WE,
  output logic [BOOT_AW-1:0] BOOT_A,
  output logic               CHR_WE,
  output logic [CHR_AW-1:0]  CHR_A,
  output logic               CART_WE,
  output logic [CART_AW-1:0] CART_A,
  output logic               BOOT_LOADED,
  output logic               CHR_LOADED,
  output logic               CART_LOADED,
  output logic [CART_AW-1:0] CART_MASK,
  output logic               SEL_ERR,
  output logic               SYS_RESB,
  output logic [15:0]        CKSUM_BOOT,
  output logic [15:0]        CKSUM_CHR,
  output logic [15:0]        CKSUM_CART,
  output logic [1:0]         state_dbg
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

  rominit_state_t     state;
  rominit_tgt_t       tgt;
  rominit_tgt_t       sel_tgt;
  logic               any_sel;
  logic               multi_sel;
  logic               enter_load;
  logic               accept;
  logic [CART_AW-1:0] cart_addr;
  logic [CART_AW-1:0] cart_max;
  logic [CART_AW-1:0] max_next;
  logic [CART_AW-1:0] mask_next;
  logic [CNT_W-1:0]   cnt;

  // Stream handshake: ROMINIT_VALID is a one-cycle strobe with no ready;
  // every strobe seen while in LOAD is written, every other strobe is dropped.
  always_comb begin
    any_sel    = ROMINIT_SEL_BOOT | ROMINIT_SEL_CHR | ROMINIT_SEL_CART;
    multi_sel  = (ROMINIT_SEL_BOOT & ROMINIT_SEL_CHR) | (ROMINIT_SEL_BOOT & ROMINIT_SEL_CART) |
                 (ROMINIT_SEL_CHR & ROMINIT_SEL_CART);
    sel_tgt    = pick_tgt(ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART);
    enter_load = any_sel && (state != LOAD);
    accept     = ROMINIT_VALID && (state == LOAD);
    cart_addr  = ROMINIT_ADDR[CART_AW-1:0];
    max_next   = cart_max;
    if (accept && (tgt == CART) && (cart_addr > cart_max)) begin
      max_next = cart_addr;
    end
  end

  // Fed with max_next so a strobe in the last LOAD cycle still counts.
  rominit_mask #(.AW(CART_AW)) u_mask (
    .max_addr (max_next),
    .mask     (mask_next)
  );

  always_ff @(posedge CLK) begin
    if (!RESB) begin
      state       <= IDLE;
      tgt         <= NONE;
      cnt         <= '0;
      cart_max    <= '0;
      MEM_D       <= '0;
      BOOT_WE     <= 1'b0;
      BOOT_A      <= '0;
      CHR_WE      <= 1'b0;
      CHR_A       <= '0;
      CART_WE     <= 1'b0;
      CART_A      <= '0;
      BOOT_LOADED <= 1'b0;
      CHR_LOADED  <= 1'b0;
      CART_LOADED <= 1'b0;
      CART_MASK   <= CART_AW'(CART_MASK_MIN);
      SEL_ERR     <= 1'b0;
      SYS_RESB    <= 1'b0;
    end else begin
      BOOT_WE  <= 1'b0;
      CHR_WE   <= 1'b0;
      CART_WE  <= 1'b0;
      cart_max <= max_next;

      if (accept) begin
        MEM_D <= ROMINIT_DATA;
        case (tgt)
          BOOT: begin
            BOOT_WE     <= 1'b1;
            BOOT_A      <= ROMINIT_ADDR[BOOT_AW-1:0];
            BOOT_LOADED <= 1'b1;
          end
          CHR: begin
            CHR_WE     <= 1'b1;
            CHR_A      <= ROMINIT_ADDR[CHR_AW-1:0];
            CHR_LOADED <= 1'b1;
          end
          CART: begin
            CART_WE     <= 1'b1;
            CART_A      <= cart_addr;
            CART_LOADED <= 1'b1;
          end
          default: ;
        endcase
      end

      case (state)
        LOAD: begin
          if (!any_sel) begin
            state <= STRETCH;
            cnt   <= '0;
            if (tgt == CART) CART_MASK <= mask_next;
          end
        end
        STRETCH: begin
          if (!any_sel) begin
            if (cnt == CNT_LAST) begin
              state    <= (BOOT_LOADED && CHR_LOADED) ? RUN : IDLE;
              SYS_RESB <= BOOT_LOADED && CHR_LOADED;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase

      // The target is latched only here, so a select change inside LOAD is
      // ignored until all selects have dropped.
      if (enter_load) begin
        state    <= LOAD;
        tgt      <= sel_tgt;
        SYS_RESB <= 1'b0;
        if (multi_sel) SEL_ERR <= 1'b1;
        case (sel_tgt)
          BOOT: BOOT_LOADED <= 1'b0;
          CHR:  CHR_LOADED  <= 1'b0;
          CART: begin
            CART_LOADED <= 1'b0;
            cart_max    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign state_dbg = state;

`ifdef ROMINIT_SINK_CKSUM_EN
  logic [15:0] sum_boot;
  logic [15:0] sum_chr;
  logic [15:0] sum_cart;

  // Sums follow the registered write port, so they trail *_WE by one cycle.
  always_ff @(posedge CLK) begin
    if (!RESB) begin
      sum_boot <= '0;
      sum_chr  <= '0;
      sum_cart <= '0;
    end else begin
      if (enter_load && (sel_tgt == BOOT)) sum_boot <= '0;
      else if (BOOT_WE)                    sum_boot <= sum_boot + {8'h00, MEM_D};
      if (enter_load && (sel_tgt == CHR))  sum_chr <= '0;
      else if (CHR_WE)                     sum_chr <= sum_chr + {8'h00, MEM_D};
      if (enter_load && (sel_tgt == CART)) sum_cart <= '0;
      else if (CART_WE)                    sum_cart <= sum_cart + {8'h00, MEM_D};
    end
  end

  assign CKSUM_BOOT = sum_boot;
  assign CKSUM_CHR  = sum_chr;
  assign CKSUM_CART = sum_cart;
`else
  assign CKSUM_BOOT = '0;
  assign CKSUM_CHR  = '0;
  assign CKSUM_CART = '0;
`endif

endmodule

// File: tb/tb_rominit_sink.sv
// Self-checking bench for rominit_sink: randomized download sessions against a
// session-level model, with a write scoreboard that also checks strobe-to-WE latency.
module tb_rominit_sink;

  localparam int RST     = 40;
  localparam int BOOT_AW = 12;
  localparam int CHR_AW  = 10;
  localparam int CART_AW = 17;
  localparam logic [1:0] T_BOOT = 2'd1;
  localparam logic [1:0] T_CHR  = 2'd2;
  localparam logic [1:0] T_CART = 2'd3;
  localparam int W = 59;  // {due_cycle[31:0], tgt[1:0], addr[16:0], data[7:0]}

  logic clk = 1'b0;
  logic resb = 1'b0;
  logic sel_boot = 1'b0, sel_chr = 1'b0, sel_cart = 1'b0;
  logic [16:0] addr = '0;
  logic [7:0] data = '0;
  logic valid = 1'b0;

  logic [7:0] mem_d;
  logic boot_we, chr_we, cart_we;
  logic [BOOT_AW-1:0] boot_a;
  logic [CHR_AW-1:0] chr_a;
  logic [CART_AW-1:0] cart_a;
  logic boot_loaded, chr_loaded, cart_loaded;
  logic [CART_AW-1:0] cart_mask;
  logic sel_err, sys_resb;
  logic [15:0] cksum_boot, cksum_chr, cksum_cart;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  int unsigned cycle = 0;
  logic [W-1:0] exp_q[$];

  // Session-level reference model
  logic m_acc = 1'b0;
  logic [1:0] m_tgt = 2'd0;
  logic m_ld [4];
  logic [16:0] m_cart_max = '0;
  logic [16:0] m_mask = 17'h007FF;
  logic [15:0] m_sum [4];
  logic m_sel_err = 1'b0;

  rominit_sink #(
    .BOOT_AW(BOOT_AW), .CHR_AW(CHR_AW), .CART_AW(CART_AW), .RST_CYCLES(RST)
  ) dut (
    .CLK(clk), .RESB(resb),
    .ROMINIT_SEL_BOOT(sel_boot), .ROMINIT_SEL_CHR(sel_chr), .ROMINIT_SEL_CART(sel_cart),
    .ROMINIT_ADDR(addr), .ROMINIT_DATA(data), .ROMINIT_VALID(valid),
    .MEM_D(mem_d),
    .BOOT_WE(boot_we), .BOOT_A(boot_a),
    .CHR_WE(chr_we), .CHR_A(chr_a),
    .CART_WE(cart_we), .CART_A(cart_a),
    .BOOT_LOADED(boot_loaded), .CHR_LOADED(chr_loaded), .CART_LOADED(cart_loaded),
    .CART_MASK(cart_mask), .SEL_ERR(sel_err), .SYS_RESB(sys_resb),
    .CKSUM_BOOT(cksum_boot), .CKSUM_CHR(cksum_chr), .CKSUM_CART(cksum_cart),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- write scoreboard ----------------
  int nwe;
  logic [W-1:0] mon_e;
  logic [26:0] mon_obs;

  always @(negedge clk) begin
    nwe = int'(boot_we) + int'(chr_we) + int'(cart_we);
    while (exp_q.size() > 0 && exp_q[0][58:27] < cycle) begin
      mon_e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_we: cycle %0d got no write, want tgt=%0d addr=%h data=%h",
               cycle, mon_e[26:25], mon_e[24:8], mon_e[7:0]);
    end
    if (nwe > 1) begin
      checks++; errors++;
      $display("FAIL multi_we: cycle %0d got we=%b%b%b, want at most one", cycle, boot_we, chr_we, cart_we);
    end else if (nwe == 1) begin
      if (boot_we)     mon_obs = {T_BOOT, 17'(boot_a), mem_d};
      else if (chr_we) mon_obs = {T_CHR, 17'(chr_a), mem_d};
      else             mon_obs = {T_CART, 17'(cart_a), mem_d};
      checks++;
      if (exp_q.size() == 0 || exp_q[0][58:27] != cycle) begin
        errors++;
        $display("FAIL unexpected_we: cycle %0d got tgt=%0d addr=%h data=%h, want no write",
                 cycle, mon_obs[26:25], mon_obs[24:8], mon_obs[7:0]);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_obs !== mon_e[26:0]) begin
          errors++;
          $display("FAIL write: cycle %0d got tgt=%0d addr=%h data=%h, want tgt=%0d addr=%h data=%h",
                   cycle, mon_obs[26:25], mon_obs[24:8], mon_obs[7:0],
                   mon_e[26:25], mon_e[24:8], mon_e[7:0]);
        end
      end
    end
  end

  // ---------------- model helpers ----------------
  function automatic logic [16:0] ref_mask(input logic [16:0] mx);
    int k = 11;
    while (((1 << k) - 1) < int'(mx)) k++;
    return 17'((1 << k) - 1);
  endfunction

  function automatic logic [16:0] tgt_amask(input logic [1:0] t);
    if (t == T_BOOT)     return 17'((1 << BOOT_AW) - 1);
    else if (t == T_CHR) return 17'((1 << CHR_AW) - 1);
    else                 return 17'((1 << CART_AW) - 1);
  endfunction

  function automatic logic [15:0] exp_cksum(input logic [1:0] t);
`ifdef ROMINIT_SINK_CKSUM_EN
    return m_sum[t];
`else
    return 16'h0000 & {16{t[0]}};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_ld[i] = 1'b0; m_sum[i] = '0; end
    m_acc = 1'b0; m_cart_max = '0; m_mask = 17'h007FF; m_sel_err = 1'b0;
  endtask

  // ---------------- driver tasks (all start and end 1 time unit after posedge) ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic open_session(input logic b, input logic c, input logic ca, input logic strobe_now);
    sel_boot = b; sel_chr = c; sel_cart = ca;
    if (strobe_now) begin addr = 17'($urandom); data = 8'($urandom); valid = 1'b1; end
    m_tgt = b ? T_BOOT : (c ? T_CHR : T_CART);
    if ((b & c) | (b & ca) | (c & ca)) m_sel_err = 1'b1;
    m_ld[m_tgt] = 1'b0; m_sum[m_tgt] = '0;
    if (m_tgt == T_CART) m_cart_max = '0;
    step(1);
    valid = 1'b0;
    m_acc = 1'b1;
  endtask

  task automatic send_byte(input logic [16:0] a, input logic [7:0] d);
    logic [16:0] ta;
    addr = a; data = d; valid = 1'b1;
    if (m_acc) begin
      ta = a & tgt_amask(m_tgt);
      exp_q.push_back({32'(cycle + 1), m_tgt, ta, d});
      m_ld[m_tgt] = 1'b1;
      m_sum[m_tgt] = m_sum[m_tgt] + 16'(d);
      if (m_tgt == T_CART && ta > m_cart_max) m_cart_max = ta;
    end
    step(1);
    valid = 1'b0;
  endtask

  task automatic close_session();
    sel_boot = 1'b0; sel_chr = 1'b0; sel_cart = 1'b0;
    if (m_tgt == T_CART) m_mask = ref_mask(m_cart_max);
    m_acc = 1'b0;
    step(1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resb = 1'b0; valid = 1'b1; addr = 17'h00123; data = 8'hA5; sel_boot = 1'b1;
    model_reset();
    step(3);
    valid = 1'b0; sel_boot = 1'b0;
    @(negedge clk);
    checks++; if ({boot_we, chr_we, cart_we} !== 3'b000) begin errors++; $display("FAIL reset_we: got %b want 000", {boot_we, chr_we, cart_we}); end
    checks++; if ({17'(boot_a), 17'(chr_a), 17'(cart_a)} !== 51'd0) begin errors++; $display("FAIL reset_addr: got %h %h %h want 0", boot_a, chr_a, cart_a); end
    checks++; if (mem_d !== 8'h00) begin errors++; $display("FAIL reset_mem_d: got %h want 00", mem_d); end
    checks++; if ({boot_loaded, chr_loaded, cart_loaded} !== 3'b000) begin errors++; $display("FAIL reset_loaded: got %b want 000", {boot_loaded, chr_loaded, cart_loaded}); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b want 0", sel_err); end
    checks++; if (sys_resb !== 1'b0) begin errors++; $display("FAIL reset_sys_resb: got %b want 0", sys_resb); end
    checks++; if (cart_mask !== 17'h007FF) begin errors++; $display("FAIL reset_mask: got %h want 007ff", cart_mask); end
    checks++; if ({cksum_boot, cksum_chr, cksum_cart} !== 48'd0) begin errors++; $display("FAIL reset_cksum: got %h %h %h want 0", cksum_boot, cksum_chr, cksum_cart); end
    @(posedge clk); #1;
    resb = 1'b1;
    step(2);
  endtask

  task automatic test_boot_session();
    open_session(1'b1, 1'b0, 1'b0, 1'b1);  // strobe in the select-rise cycle is dropped
    for (int i = 0; i < 4096; i++) send_byte(17'(i), 8'($urandom));
    close_session();
    @(negedge clk);
    checks++; if ({boot_loaded, chr_loaded, cart_loaded} !== {m_ld[T_BOOT], m_ld[T_CHR], m_ld[T_CART]}) begin errors++; $display("FAIL boot_loaded: got %b want %b", {boot_loaded, chr_loaded, cart_loaded}, {m_ld[T_BOOT], m_ld[T_CHR], m_ld[T_CART]}); end
    step(RST + 4);
    for (int i = 0; i < 6; i++) send_byte(17'($urandom), 8'($urandom));  // no session: dropped
    @(negedge clk);
    checks++; if (sys_resb !== 1'b0) begin errors++; $display("FAIL boot_only_sys_resb: got %b want 0", sys_resb); end
    checks++; if (cksum_boot !== exp_cksum(T_BOOT)) begin errors++; $display("FAIL boot_cksum: got %h want %h", cksum_boot, exp_cksum(T_BOOT)); end
    step(1);
  endtask

  task automatic test_full_load();
    int rise;
    open_session(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      send_byte(17'(i) | (17'($urandom_range(0, 127)) << CHR_AW), 8'hFF);
      if ($urandom_range(0, 3) == 0) step(1);
    end
    close_session();
    step(2);
    @(negedge clk);
    checks++; if (cksum_chr !== exp_cksum(T_CHR)) begin errors++; $display("FAIL chr_cksum: got %h want %h", cksum_chr, exp_cksum(T_CHR)); end
    checks++; if (chr_loaded !== 1'b1) begin errors++; $display("FAIL chr_loaded: got %b want 1", chr_loaded); end
    step(RST + 2);
    open_session(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      send_byte(17'($urandom_range(0, 17'h2FFE)), 8'($urandom));
      if (i == 150) send_byte(17'h02FFF, 8'($urandom));
    end
    close_session();
    @(negedge clk);
    checks++; if (cart_mask !== m_mask) begin errors++; $display("FAIL cart_mask_3fff: got %h want %h", cart_mask, m_mask); end
    checks++; if (cart_loaded !== 1'b1) begin errors++; $display("FAIL cart_loaded: got %b want 1", cart_loaded); end
    rise = 0;
    for (int n = 1; n <= RST + 10; n++) begin
      if (sys_resb === 1'b1) begin rise = n; break; end
      @(negedge clk);
    end
    checks++; if (rise != RST + 1) begin errors++; $display("FAIL sys_resb_rise: got %0d cycles want %0d", rise, RST + 1); end
    checks++; if (cksum_cart !== exp_cksum(T_CART)) begin errors++; $display("FAIL cart_cksum: got %h want %h", cksum_cart, exp_cksum(T_CART)); end
    step(1);
  endtask

  task automatic test_cart_masks();
    open_session(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (sys_resb !== 1'b0) begin errors++; $display("FAIL run_to_load_sys_resb: got %b want 0", sys_resb); end
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) send_byte(17'($urandom_range(0, 16'h000F)), 8'($urandom));
    send_byte(17'h00010, 8'($urandom));
    close_session();
    @(negedge clk);
    checks++; if (cart_mask !== m_mask) begin errors++; $display("FAIL cart_mask_small: got %h want %h", cart_mask, m_mask); end
    step(RST + 2);
    @(negedge clk);
    checks++; if (sys_resb !== (m_ld[T_BOOT] & m_ld[T_CHR])) begin errors++; $display("FAIL run_sys_resb: got %b want %b", sys_resb, m_ld[T_BOOT] & m_ld[T_CHR]); end
    step(1);
    // Full-range address.
    open_session(1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(17'h00800, 8'($urandom));
    send_byte(17'h1FFFF, 8'($urandom));
    close_session();
    @(negedge clk);
    checks++; if (cart_mask !== m_mask) begin errors++; $display("FAIL cart_mask_max: got %h want %h", cart_mask, m_mask); end
    step(RST + 2);
    // Empty session.
    open_session(1'b0, 1'b0, 1'b1, 1'b0);
    step(3);
    close_session();
    @(negedge clk);
    checks++; if (cart_mask !== m_mask) begin errors++; $display("FAIL cart_mask_empty: got %h want %h", cart_mask, m_mask); end
    checks++; if (cart_loaded !== m_ld[T_CART]) begin errors++; $display("FAIL cart_loaded_empty: got %b want %b", cart_loaded, m_ld[T_CART]); end
    step(RST + 2);
  endtask

  task automatic test_sel_err();
    open_session(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(17'($urandom), 8'($urandom));
    sel_boot = 1'b0;  // cart still high: target must stay boot
    for (int i = 0; i < 10; i++) send_byte(17'($urandom), 8'($urandom));
    close_session();
    @(negedge clk);
    checks++; if (sel_err !== m_sel_err) begin errors++; $display("FAIL sel_err_set: got %b want %b", sel_err, m_sel_err); end
    step(RST + 2);
    @(negedge clk);
    checks++; if (sel_err !== m_sel_err) begin errors++; $display("FAIL sel_err_sticky: got %b want %b", sel_err, m_sel_err); end
    checks++; if (sys_resb !== (m_ld[T_BOOT] & m_ld[T_CHR])) begin errors++; $display("FAIL sel_err_sys_resb: got %b want %b", sys_resb, m_ld[T_BOOT] & m_ld[T_CHR]); end
    step(1);
  endtask

  task automatic test_mid_reset();
    open_session(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) send_byte(17'($urandom), 8'($urandom));
    resb = 1'b0; sel_cart = 1'b0;
    model_reset();
    step(1);
    resb = 1'b1;
    @(negedge clk);
    checks++; if ({boot_loaded, chr_loaded, cart_loaded, sel_err, sys_resb} !== 5'b00000) begin errors++; $display("FAIL midrst_flags: got %b want 00000", {boot_loaded, chr_loaded, cart_loaded, sel_err, sys_resb}); end
    checks++; if (cart_mask !== m_mask) begin errors++; $display("FAIL midrst_mask: got %h want %h", cart_mask, m_mask); end
    checks++; if ({cksum_boot, cksum_chr, cksum_cart} !== 48'd0) begin errors++; $display("FAIL midrst_cksum: got %h %h %h want 0", cksum_boot, cksum_chr, cksum_cart); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_byte(17'($urandom), 8'($urandom));  // dropped
    @(negedge clk);
    checks++; if (cart_loaded !== 1'b0) begin errors++; $display("FAIL midrst_dropped: got %b want 0", cart_loaded); end
    @(posedge clk); #1;
    // Select held high through reset starts a new session.
    sel_cart = 1'b1;
    step(1);
    resb = 1'b0;
    step(1);
    resb = 1'b1;
    step(1);
    m_acc = 1'b1; m_tgt = T_CART;
    for (int i = 0; i < 5; i++) send_byte(17'($urandom_range(0, 17'h0FFF)), 8'($urandom));
    close_session();
    @(negedge clk);
    checks++; if (cart_loaded !== m_ld[T_CART]) begin errors++; $display("FAIL held_sel_session: got %b want %b", cart_loaded, m_ld[T_CART]); end
    checks++; if (cart_mask !== m_mask) begin errors++; $display("FAIL held_sel_mask: got %h want %h", cart_mask, m_mask); end
    step(3);
  endtask

  initial begin
    test_reset();
    test_boot_session();
    test_full_load();
    test_cart_masks();
    test_sel_err();
    test_mid_reset();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending writes want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
